// File: rtl/answer_check_logic.sv
// Game-round controller placed after the question selector.
// It requests a question, latches the answer, and runs the per-question
// countdown. It grades the player's submission and keeps the score, lives and
// game-over status for the display and LED blocks.
//
// Handshake: question_enable is a one-cycle request. The selector replies
// later with a one-cycle question_ready, and correct_ans / selected_q_id are
// valid in that same cycle. A reply that arrives outside WAIT_Q is ignored.
// If no reply arrives within 8 cycles, the request is repeated.
module answer_check_logic #(
  parameter int TIME_LIMIT   = 9,
  parameter int RESULT_TICKS = 2,
  parameter int START_LIVES  = 3,
  parameter int SCORE_STEP   = 1
) (
  input  logic       clk_100mhz,
  input  logic       reset,
  input  logic       game_tick,
  input  logic       start,
  input  logic       submit,
  input  logic [3:0] answer_in,
  input  logic       question_ready,
  input  logic [3:0] correct_ans,
  input  logic [3:0] selected_q_id,
  output logic       question_enable,
  output logic [3:0] shown_q_id,
  output logic [3:0] time_left,
  output logic       result_valid,
  output logic       result_correct,
  output logic       result_timeout,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT_Q = 3'd2,
    ANSWER = 3'd3,
    RESULT = 3'd4,
    OVER   = 3'd5
  } state_t;

  localparam logic [3:0] TIME_LIMIT_V  = 4'(TIME_LIMIT);
  localparam logic [3:0] RES_LAST_V    = 4'(RESULT_TICKS - 1);
  localparam logic [1:0] START_LIVES_V = 2'(START_LIVES);
  localparam logic [8:0] SCORE_STEP_V  = 9'(SCORE_STEP);
  localparam logic [2:0] WAIT_LAST_V   = 3'd7;

  state_t     state_q, state_d;
  logic [3:0] ans_q, ans_d;
  logic [3:0] shown_q_id_q, shown_q_id_d;
  logic [3:0] time_left_q, time_left_d;
  logic       result_correct_q, result_correct_d;
  logic       result_timeout_q, result_timeout_d;
  logic [7:0] score_q, score_d;
  logic [1:0] lives_q, lives_d;
  logic [2:0] wait_cnt_q, wait_cnt_d;
  logic [3:0] res_cnt_q, res_cnt_d;

  logic [8:0] score_sum;
  logic [7:0] score_sat;
  logic [1:0] lives_dec;

  // Saturating score increment and floor-at-zero life loss used on grading
  always_comb begin
    score_sum = {1'b0, score_q} + SCORE_STEP_V;
    score_sat = (score_sum > 9'd255) ? 8'hFF : score_sum[7:0];
    lives_dec = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
  end

  // Next-state and register updates for the round sequence
  always_comb begin
    state_d          = state_q;
    ans_d            = ans_q;
    shown_q_id_d     = shown_q_id_q;
    time_left_d      = time_left_q;
    result_correct_d = result_correct_q;
    result_timeout_d = result_timeout_q;
    score_d          = score_q;
    lives_d          = lives_q;
    wait_cnt_d       = wait_cnt_q;
    res_cnt_d        = res_cnt_q;

    case (state_q)
      IDLE, OVER: begin
        // A new game starts from either state with fresh score and lives
        if (start) begin
          score_d          = 8'd0;
          lives_d          = START_LIVES_V;
          result_correct_d = 1'b0;
          result_timeout_d = 1'b0;
          state_d          = REQ;
        end
      end
      REQ: begin
        wait_cnt_d = 3'd0;
        state_d    = WAIT_Q;
      end
      WAIT_Q: begin
        if (question_ready) begin
          ans_d        = correct_ans;
          shown_q_id_d = selected_q_id;
          time_left_d  = TIME_LIMIT_V;
          state_d      = ANSWER;
        end else if (wait_cnt_q == WAIT_LAST_V) begin
          state_d = REQ;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      ANSWER: begin
        // A submit beats a coincident tick; time_left is then left frozen
        if (submit) begin
          result_correct_d = (answer_in == ans_q);
          result_timeout_d = 1'b0;
          if (answer_in == ans_q) score_d = score_sat;
          else                    lives_d = lives_dec;
          res_cnt_d = 4'd0;
          state_d   = RESULT;
        end else if (game_tick) begin
          if (time_left_q == 4'd1) begin
            time_left_d      = 4'd0;
            result_timeout_d = 1'b1;
            result_correct_d = 1'b0;
            lives_d          = lives_dec;
            res_cnt_d        = 4'd0;
            state_d          = RESULT;
          end else begin
            time_left_d = time_left_q - 4'd1;
          end
        end
      end
      RESULT: begin
        if (game_tick) begin
          if (res_cnt_q == RES_LAST_V) begin
            if (lives_q == 2'd0) begin
              state_d = OVER;
            end else begin
              result_correct_d = 1'b0;
              result_timeout_d = 1'b0;
              state_d          = REQ;
            end
          end else begin
            res_cnt_d = res_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      state_q          <= IDLE;
      ans_q            <= 4'd0;
      shown_q_id_q     <= 4'd0;
      time_left_q      <= 4'd0;
      result_correct_q <= 1'b0;
      result_timeout_q <= 1'b0;
      score_q          <= 8'd0;
      lives_q          <= START_LIVES_V;
      wait_cnt_q       <= 3'd0;
      res_cnt_q        <= 4'd0;
    end else begin
      state_q          <= state_d;
      ans_q            <= ans_d;
      shown_q_id_q     <= shown_q_id_d;
      time_left_q      <= time_left_d;
      result_correct_q <= result_correct_d;
      result_timeout_q <= result_timeout_d;
      score_q          <= score_d;
      lives_q          <= lives_d;
      wait_cnt_q       <= wait_cnt_d;
      res_cnt_q        <= res_cnt_d;
    end
  end

  // Outputs are decoded straight from state or driven from registers
  always_comb begin
    question_enable = (state_q == REQ);
    result_valid    = (state_q == RESULT);
    game_over       = (state_q == OVER);
    shown_q_id      = shown_q_id_q;
    time_left       = time_left_q;
    result_correct  = result_correct_q;
    result_timeout  = result_timeout_q;
    score           = score_q;
    lives           = lives_q;
    state_dbg       = state_q;
  end

endmodule

// File: tb/tb_answer_check_logic.sv
// Bench for answer_check_logic. A game-level model tracks score, lives,
// countdown and result flags, and each step compares the DUT against it.
module tb_answer_check_logic;

  localparam int TIME_LIMIT   = 9;
  localparam int RESULT_TICKS = 2;
  localparam int START_LIVES  = 3;
  localparam int SCORE_STEP   = 1;

  logic       clk_100mhz = 1'b0;
  logic       reset;
  logic       game_tick, start, submit, question_ready;
  logic [3:0] answer_in, correct_ans, selected_q_id;
  logic       question_enable, result_valid, result_correct, result_timeout, game_over;
  logic [3:0] shown_q_id, time_left;
  logic [7:0] score;
  logic [1:0] lives;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  // game-level model
  int m_score, m_lives, m_tl, m_qid, m_ans;
  bit m_correct, m_timeout, m_over;

  answer_check_logic #(
    .TIME_LIMIT(TIME_LIMIT), .RESULT_TICKS(RESULT_TICKS),
    .START_LIVES(START_LIVES), .SCORE_STEP(SCORE_STEP)
  ) dut (
    .clk_100mhz(clk_100mhz), .reset(reset), .game_tick(game_tick),
    .start(start), .submit(submit), .answer_in(answer_in),
    .question_ready(question_ready), .correct_ans(correct_ans),
    .selected_q_id(selected_q_id), .question_enable(question_enable),
    .shown_q_id(shown_q_id), .time_left(time_left), .result_valid(result_valid),
    .result_correct(result_correct), .result_timeout(result_timeout),
    .score(score), .lives(lives), .game_over(game_over), .state_dbg(state_dbg)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one clock; outputs settle #1 after the edge, pulses drop back to 0
  task automatic cycle();
    @(posedge clk_100mhz);
    #1;
    start = 1'b0; submit = 1'b0; game_tick = 1'b0; question_ready = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_qen"}, 32'(question_enable), 0);
    check({tag, "_qid"}, 32'(shown_q_id), 0);
    check({tag, "_tl"}, 32'(time_left), 0);
    check({tag, "_rv"}, 32'(result_valid), 0);
    check({tag, "_rc"}, 32'(result_correct), 0);
    check({tag, "_rt"}, 32'(result_timeout), 0);
    check({tag, "_score"}, 32'(score), 0);
    check({tag, "_lives"}, 32'(lives), START_LIVES);
    check({tag, "_over"}, 32'(game_over), 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    cycle();
    m_score = 0; m_lives = START_LIVES; m_correct = 0; m_timeout = 0; m_over = 0;
    check("start_qen", 32'(question_enable), 1);
    check("start_score", 32'(score), 0);
    check("start_lives", 32'(lives), START_LIVES);
    check("start_over", 32'(game_over), 0);
    check("start_rc", 32'(result_correct), 0);
    check("start_rt", 32'(result_timeout), 0);
  endtask

  // called while the DUT shows a request; replies after 'delay' idle WAIT_Q cycles
  task automatic get_question(input int qid, input int ans, input int delay);
    check("req_qen", 32'(question_enable), 1);
    cycle();
    for (int i = 0; i < delay; i++) begin
      check("wait_qen_low", 32'(question_enable), 0);
      if ($urandom_range(0, 1) == 1) game_tick = 1'b1;
      cycle();
    end
    check("wait_qen_low", 32'(question_enable), 0);
    question_ready = 1'b1;
    selected_q_id  = 4'(qid);
    correct_ans    = 4'(ans);
    cycle();
    selected_q_id = 4'($urandom_range(0, 15));
    correct_ans   = 4'($urandom_range(0, 15));
    m_qid = qid; m_ans = ans; m_tl = TIME_LIMIT;
    check("q_shown", 32'(shown_q_id), 32'(m_qid));
    check("q_tl", 32'(time_left), 32'(m_tl));
    check("q_rv", 32'(result_valid), 0);
    check("q_qen", 32'(question_enable), 0);
  endtask

  task automatic ticks_in_answer(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        answer_in = 4'($urandom_range(0, 15));
        cycle();
        check("ans_idle_tl", 32'(time_left), 32'(m_tl));
      end
      game_tick = 1'b1;
      cycle();
      m_tl = m_tl - 1;
      check("ans_tick_tl", 32'(time_left), 32'(m_tl));
      check("ans_tick_rv", 32'(result_valid), 0);
    end
  endtask

  task automatic submit_answer(input int a, input bit with_tick);
    answer_in = 4'(a);
    submit    = 1'b1;
    game_tick = with_tick;
    cycle();
    answer_in = 4'($urandom_range(0, 15));
    if (a == m_ans) begin
      m_correct = 1;
      m_score   = (m_score + SCORE_STEP > 255) ? 255 : m_score + SCORE_STEP;
    end else begin
      m_correct = 0;
      if (m_lives > 0) m_lives = m_lives - 1;
    end
    m_timeout = 0;
    check("sub_rv", 32'(result_valid), 1);
    check("sub_rc", 32'(result_correct), 32'(m_correct));
    check("sub_rt", 32'(result_timeout), 0);
    check("sub_tl", 32'(time_left), 32'(m_tl));
    check("sub_score", 32'(score), 32'(m_score));
    check("sub_lives", 32'(lives), 32'(m_lives));
  endtask

  task automatic timeout_round();
    while (m_tl > 1) ticks_in_answer(1);
    game_tick = 1'b1;
    cycle();
    m_tl = 0; m_timeout = 1; m_correct = 0;
    if (m_lives > 0) m_lives = m_lives - 1;
    check("to_rv", 32'(result_valid), 1);
    check("to_rt", 32'(result_timeout), 1);
    check("to_rc", 32'(result_correct), 0);
    check("to_tl", 32'(time_left), 0);
    check("to_lives", 32'(lives), 32'(m_lives));
    check("to_score", 32'(score), 32'(m_score));
  endtask

  // waits out the result display, with ignored pulses sprinkled in
  task automatic finish_result();
    for (int i = 0; i < RESULT_TICKS; i++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        submit = ($urandom_range(0, 1) == 1);
        start = ($urandom_range(0, 1) == 1);
        question_ready = ($urandom_range(0, 1) == 1);
        answer_in = 4'(m_ans);
        cycle();
        check("res_hold_rv", 32'(result_valid), 1);
        check("res_hold_rc", 32'(result_correct), 32'(m_correct));
        check("res_hold_rt", 32'(result_timeout), 32'(m_timeout));
        check("res_hold_score", 32'(score), 32'(m_score));
        check("res_hold_lives", 32'(lives), 32'(m_lives));
      end
      game_tick = 1'b1;
      cycle();
      if (i < RESULT_TICKS - 1) begin
        check("res_mid_rv", 32'(result_valid), 1);
      end else if (m_lives == 0) begin
        m_over = 1;
        check("res_over", 32'(game_over), 1);
        check("res_over_rv", 32'(result_valid), 0);
        check("res_over_qen", 32'(question_enable), 0);
      end else begin
        m_correct = 0; m_timeout = 0;
        check("res_next_qen", 32'(question_enable), 1);
        check("res_next_rv", 32'(result_valid), 0);
        check("res_next_rc", 32'(result_correct), 0);
        check("res_next_rt", 32'(result_timeout), 0);
      end
    end
  endtask

  function automatic int wrong_of(input int ans);
    return (ans + int'($urandom_range(1, 15))) % 16;
  endfunction

  initial begin
    int q, a, outcome;
    reset = 1'b1; game_tick = 1'b0; start = 1'b0; submit = 1'b0;
    question_ready = 1'b0; answer_in = 4'd0; correct_ans = 4'd0; selected_q_id = 4'd0;
    m_score = 0; m_lives = START_LIVES; m_tl = 0; m_qid = 0; m_ans = 0;
    m_correct = 0; m_timeout = 0; m_over = 0;

    // Reset state
    repeat (3) cycle();
    check_reset_vals("rst");
    reset = 1'b0;
    cycle();

    // Submit in IDLE is ignored
    submit = 1'b1;
    cycle();
    check("idle_sub_qen", 32'(question_enable), 0);
    check("idle_sub_rv", 32'(result_valid), 0);

    // Start, then q_id 3 / ans 9 answered correctly after 2 ticks
    do_start();
    get_question(3, 9, 0);
    ticks_in_answer(2);
    check("dir_tl7", 32'(time_left), 7);
    submit_answer(9, 0);
    check("dir_score1", 32'(score), 1);
    check("dir_lives3", 32'(lives), 3);
    finish_result();

    // Wrong answer 14 against 15
    get_question(int'($urandom_range(0, 15)), 15, 0);
    submit_answer(14, 0);
    check("dir_lives2", 32'(lives), 2);
    check("dir_score_keep", 32'(score), 1);
    finish_result();

    // Full timeout: time_left runs 9..0
    get_question(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1);
    timeout_round();
    check("dir_lives1", 32'(lives), 1);
    finish_result();

    // Submit coincident with the final tick counts as a submit
    get_question(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 0);
    ticks_in_answer(TIME_LIMIT - 1);
    check("dir_tl1", 32'(time_left), 1);
    submit_answer(m_ans, 1);
    check("dir_tie_rt", 32'(result_timeout), 0);
    check("dir_tie_score", 32'(score), 2);
    finish_result();

    // Third failure ends the game
    get_question(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 0);
    submit_answer(wrong_of(m_ans), 0);
    finish_result();
    check("dir_over_lives", 32'(lives), 0);
    check("dir_over_flag", 32'(m_over), 1);

    // Submit in OVER changes nothing
    answer_in = 4'(m_ans);
    submit = 1'b1;
    cycle();
    check("over_sub_over", 32'(game_over), 1);
    check("over_sub_score", 32'(score), 32'(m_score));
    check("over_sub_lives", 32'(lives), 0);
    check("over_sub_qid", 32'(shown_q_id), 32'(m_qid));
    check("over_sub_rv", 32'(result_valid), 0);

    // Restart from OVER
    do_start();

    // Selector silent: re-request 9 cycles after the first pulse
    check("rereq_first", 32'(question_enable), 1);
    for (int i = 1; i <= 8; i++) begin
      cycle();
      check("rereq_gap", 32'(question_enable), 0);
    end
    cycle();
    check("rereq_pulse", 32'(question_enable), 1);

    // Reply on the last allowed WAIT_Q cycle is still accepted
    get_question(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 7);
    submit_answer(m_ans, 0);
    finish_result();

    // Randomised rounds with mixed outcomes
    for (int r = 0; r < 20; r++) begin
      if (m_over) do_start();
      q = int'($urandom_range(0, 15));
      a = int'($urandom_range(0, 15));
      get_question(q, a, int'($urandom_range(0, 3)));
      outcome = int'($urandom_range(0, 2));
      if (outcome == 2) begin
        timeout_round();
      end else begin
        ticks_in_answer(int'($urandom_range(0, TIME_LIMIT - 1)));
        submit_answer(outcome == 0 ? a : wrong_of(a), ($urandom_range(0, 1) == 1));
      end
      finish_result();
    end

    // Drive the score up to saturation, then one more correct answer
    if (m_over) do_start();
    while (m_score < 255) begin
      get_question(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 1)));
      ticks_in_answer(int'($urandom_range(0, 2)));
      submit_answer(m_ans, ($urandom_range(0, 1) == 1));
      finish_result();
    end
    check("sat_255", 32'(score), 255);
    get_question(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 0);
    submit_answer(m_ans, 0);
    check("sat_hold", 32'(score), 255);
    finish_result();

    // Reset in the middle of ANSWER
    get_question(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 0);
    ticks_in_answer(1);
    reset = 1'b1;
    answer_in = 4'(m_ans);
    submit = 1'b1;
    cycle();
    check_reset_vals("mid_rst");
    reset = 1'b0;
    cycle();
    check("post_rst_qen", 32'(question_enable), 0);
    check("post_rst_rv", 32'(result_valid), 0);
    do_start();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/answer_check_logic.md
Name: answer_check_logic

Overview:
- Game-round controller that sits directly downstream of the question selector.
- Requests a question with a one-cycle enable and latches the returned question ID and correct answer.
- Runs a per-question countdown on game_tick and compares the player's 4-bit switch answer on submit.
- Produces result flags, score, lives and game-over status for the display and LED blocks.

Parameters:
- TIME_LIMIT, 9, game_ticks allowed per question (1..15).
- RESULT_TICKS, 2, game_ticks the result is held before the next question (1..15).
- START_LIVES, 3, lives at game start (1..3).
- SCORE_STEP, 1, points added per correct answer.

Ports:
- clk_100mhz  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- game_tick  in  1  single-cycle timebase pulse.
- start  in  1  single-cycle debounced start pulse.
- submit  in  1  single-cycle debounced submit pulse.
- answer_in  in  4  player answer from switches.
- question_ready  in  1  selector pulse: correct_ans and selected_q_id are valid this cycle.
- correct_ans  in  4  answer for the selected question.
- selected_q_id  in  4  ID of the selected question.
- question_enable  out  1  one-cycle request to the selector.
- shown_q_id  out  4  latched question ID for display.
- time_left  out  4  remaining game_ticks.
- result_valid  out  1  high during the RESULT state.
- result_correct  out  1  last answer was correct.
- result_timeout  out  1  last round timed out.
- score  out  8  saturating score.
- lives  out  2  remaining lives.
- game_over  out  1  high in the OVER state.

Behaviour:
- Reset values: state IDLE; every output 0, except lives = START_LIVES.
- Reset mid-round: the round is abandoned; nothing is latched or scored.
- FSM states: IDLE, REQ, WAIT_Q, ANSWER, RESULT, OVER.
- IDLE:
  - start -> REQ.
  - score cleared to 0, lives loaded with START_LIVES on the same edge.
- REQ:
  - question_enable = 1 for exactly one cycle.
  - Unconditionally -> WAIT_Q.
- WAIT_Q:
  - On question_ready: latch correct_ans internally, shown_q_id <= selected_q_id, time_left <= TIME_LIMIT; -> ANSWER.
  - No question_ready within 8 cycles: -> REQ (re-request).
- ANSWER, in priority order:
  - submit: result_correct <= (answer_in == latched answer), result_timeout <= 0; -> RESULT. Submit wins over a coincident game_tick; time_left is frozen.
  - Otherwise game_tick with time_left == 1: time_left <= 0, result_timeout <= 1, result_correct <= 0; -> RESULT.
  - Otherwise game_tick: time_left decrements by 1.
- Score and lives update on the ANSWER -> RESULT edge:
  - Correct: score <= min(score + SCORE_STEP, 255).
  - Wrong or timeout: lives <= lives - 1; lives never goes below 0.
- RESULT:
  - result_valid = 1; result_correct and result_timeout hold.
  - Count RESULT_TICKS game_ticks, then:
    - lives == 0 -> OVER.
    - otherwise -> REQ, clearing result_correct and result_timeout.
- OVER:
  - game_over = 1; score, lives and shown_q_id are held.
  - start -> IDLE behaviour (score/lives reinitialised) and -> REQ on the same edge.
- Ignored inputs:
  - submit outside ANSWER.
  - start outside IDLE/OVER.
  - question_ready outside WAIT_Q.
- Timing:
  - Latency from question_enable to ANSWER is 2 cycles with a selector that answers next cycle.
  - question_enable is never asserted on two consecutive cycles.

Test Plan:
- Reset then start -> question_enable high exactly 1 cycle later for 1 cycle; score = 0, lives = 3.
- Selector returns q_id = 3, ans = 9; answer_in = 9, submit after 2 ticks -> result_correct = 1, result_timeout = 0, time_left = 7, score = 1, lives = 3; after 2 ticks, new question_enable pulse.
- Selector returns ans = 15; answer_in = 14, submit -> result_correct = 0, lives = 2, score unchanged.
- No submit for 9 game_ticks -> time_left counts 9..0, result_timeout = 1, lives decremented; submit and game_tick in the same cycle at time_left = 1 -> scored as a submit, not a timeout.
- Three failures -> game_over = 1, lives = 0; a submit in OVER has no effect; start -> score = 0, lives = 3, question_enable pulses.
- question_ready withheld for 8 cycles -> question_enable re-pulses; score preset to 255 plus a correct answer -> score stays 255; reset asserted in ANSWER -> all outputs return to reset values next cycle.
